// File: rtl/up_down_counter_4bit.sv
// ============================================================================
// Module   : up_down_counter_4bit
// Function : free-running WIDTH-bit up/down counter with async active-high reset.
//            Define UDC_TC_OUT_EN to add the combinational terminal-count TC output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module up_down_counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             UPDN,
`ifdef UDC_TC_OUT_EN
  output logic             TC,
`endif
  output logic [WIDTH-1:0] COUNT
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Both directions wrap naturally through the fixed register width.
  always_comb begin
    count_d = count_q;
    if (UPDN) count_d = count_q + C_ONE;
    else      count_d = count_q - C_ONE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) count_q <= '0;
    else       count_q <= count_d;
  end

  assign COUNT = count_q;

`ifdef UDC_TC_OUT_EN
  // Flags the value that is about to wrap in the currently selected direction.
  assign TC = UPDN ? (count_q == '1) : (count_q == '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_up_down_counter_4bit.sv
// ============================================================================
// Module   : tb_up_down_counter_4bit
// Function : directed self-checking bench for up_down_counter_4bit (WIDTH=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_up_down_counter_4bit;

  logic       CLK;
  logic       RESET;
  logic       UPDN;
  logic [3:0] COUNT;
`ifdef UDC_TC_OUT_EN
  logic       TC;
`endif

  int n_checks = 0;
  int n_errors = 0;

  up_down_counter_4bit #(.WIDTH(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .UPDN  (UPDN),
`ifdef UDC_TC_OUT_EN
    .TC    (TC),
`endif
    .COUNT (COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Terminal count expected from the hand-computed count and current direction.
  task automatic check_tc(input string tag, input logic [3:0] exp_count);
`ifdef UDC_TC_OUT_EN
    check(tag, {31'd0, TC}, {31'd0, (UPDN && exp_count == 4'd15) || (!UPDN && exp_count == 4'd0)});
`endif
  endtask

  task automatic check_count(input string tag, input logic [3:0] exp_count);
    check(tag, {28'd0, COUNT}, {28'd0, exp_count});
    check_tc({tag, "_tc"}, exp_count);
  endtask

  logic [3:0] down_seq [8];

  initial begin
    down_seq = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15};

    // Scenario 1: reset, then count up from t=10.
    RESET = 1'b1;
    UPDN  = 1'b1;
    #2  check_count("reset_hold", 4'd0);           // t=2
    #8  RESET = 1'b0;                              // t=10
    #1  check_count("post_release", 4'd0);         // t=11, before edge at 15
    #9;                                            // t=20
    for (int i = 1; i <= 7; i++) begin
      check_count($sformatf("up_%0d", i), 4'(i));
      if (i < 7) #10;
    end                                            // t=80

    // Scenario 2: direction change, no skipped or doubled step.
    UPDN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #10 check_count($sformatf("down_%0d", i), down_seq[i]);
    end                                            // t=160

    // Scenario 3: asynchronous reset between edges.
    RESET = 1'b1;
    #1  check_count("async_clear", 4'd0);          // t=161
    for (int i = 0; i < 3; i++) begin
      #10 check_count($sformatf("reset_held_%0d", i), 4'd0);
    end

    // Scenario 4: up wrap over 17 edges from reset.
    UPDN = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge CLK);
      check_count($sformatf("wrap_%0d", i), 4'(i));
`ifdef UDC_TC_OUT_EN
      if (i == 15) begin
        UPDN = 1'b0;
        #1 check("tc_drop_on_flip", {31'd0, TC}, 32'd0);
        UPDN = 1'b1;
        #1 check("tc_restore", {31'd0, TC}, 32'd1);
      end
`endif
    end

    // Scenario 5: down from reset with release coincident with an edge.
    UPDN = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    #1 check_count("down_reset", 4'd0);
    @(posedge CLK);
    // Non-blocking so the DUT samples RESET still high on this very edge.
    RESET <= 1'b0;
    @(negedge CLK);
    check_count("edge_release_ignored", 4'd0);
    @(negedge CLK); check_count("down_from_reset_0", 4'd15);
    @(negedge CLK); check_count("down_from_reset_1", 4'd14);
    @(negedge CLK); check_count("down_from_reset_2", 4'd13);

    // Asynchronous clear while CLK is high.
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1 check_count("async_clear_high_phase", 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
